// File: rtl/glyph_pkg.sv
// Shared constants and glyph bitmap table for the glyph pixel pipeline.
package glyph_pkg;

   localparam int unsigned GLYPH_W    = 16;
   localparam int unsigned GLYPH_H    = 32;
   localparam int unsigned NUM_GLYPHS = 16;
   localparam int unsigned COLOR_W    = 12;

   localparam logic [11:0] COLOR_GREEN = 12'h0F0;
   localparam logic [11:0] COLOR_BLACK = 12'h000;

   // Row words are MSB-first: column 0 of a glyph is bit GLYPH_W-1.
   localparam logic [GLYPH_W-1:0] GLYPH_TABLE [NUM_GLYPHS][GLYPH_H] = '{
      0: '{15: 16'h0FE0, 16: 16'h0FE0, 17: 16'h0FE0, default: 16'h0000},
      1: '{ 7: 16'h0300,  8: 16'h0780,  9: 16'h0780, 10: 16'h0300,
           21: 16'h0300, 22: 16'h0780, 23: 16'h0780, 24: 16'h0300,
           default: 16'h0000},
      2: '{16'h0780, 16'h0780, 16'h0300, 16'h0300, 16'h0780, 16'h0780, 16'h0300, 16'h0300,
           16'h0780, 16'h0780, 16'h0300, 16'h0300, 16'h0780, 16'h0780, 16'h0300, 16'h0300,
           16'h0780, 16'h0780, 16'h0300, 16'h0300, 16'h0780, 16'h0780, 16'h0300, 16'h0300,
           16'h0780, 16'h0780, 16'h0300, 16'h0300, 16'h0780, 16'h0780, 16'h0300, 16'h0300},
      default: '{default: 16'h0000}
   };

endpackage

// File: rtl/glyph_rom.sv
// Synchronous one-cycle glyph ROM; address is {glyph index, glyph row}.
module glyph_rom
   import glyph_pkg::*;
#(
   parameter int unsigned GLYPH_W    = glyph_pkg::GLYPH_W,
   parameter int unsigned GLYPH_H    = glyph_pkg::GLYPH_H,
   parameter int unsigned NUM_GLYPHS = glyph_pkg::NUM_GLYPHS
) (
   input  logic                                           clk,
   input  logic [$clog2(NUM_GLYPHS)+$clog2(GLYPH_H)-1:0]  addr,
   output logic [GLYPH_W-1:0]                             data
);

   localparam int unsigned IDX_W = $clog2(NUM_GLYPHS);
   localparam int unsigned ROW_W = $clog2(GLYPH_H);

   logic [IDX_W-1:0] w_idx;
   logic [ROW_W-1:0] w_row;

   assign {w_idx, w_row} = addr;

   // Indices past the populated glyph count read as blank rows.
   always_ff @(posedge clk) begin
      if (32'(w_idx) < NUM_GLYPHS) begin
         data <= GLYPH_W'(GLYPH_TABLE[w_idx][w_row]);
      end else begin
         data <= '0;
      end
   end

endmodule

// File: rtl/glyph_pixel_pipe.sv
// Two-stage glyph renderer: ROM fetch, then bit select and colour mux.
// Optional blink support is compiled in with `define GLYPH_BLINK_EN.
module glyph_pixel_pipe
   import glyph_pkg::*;
#(
   parameter int unsigned GLYPH_W      = glyph_pkg::GLYPH_W,
   parameter int unsigned GLYPH_H      = glyph_pkg::GLYPH_H,
   parameter int unsigned NUM_GLYPHS   = glyph_pkg::NUM_GLYPHS,
   parameter int unsigned COLOR_W      = glyph_pkg::COLOR_W,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          pix_valid,
   input  logic [$clog2(NUM_GLYPHS)-1:0] glyph_idx,
   input  logic [$clog2(GLYPH_H)-1:0]    glyph_row,
   input  logic [$clog2(GLYPH_W)-1:0]    glyph_col,
   input  logic                          hsync_in,
   input  logic                          vsync_in,
   input  logic                          blink,
   input  logic                          invert,
   input  logic [COLOR_W-1:0]            fg_color,
   input  logic [COLOR_W-1:0]            bg_color,
   output logic [COLOR_W-1:0]            rgb,
   output logic                          hsync_out,
   output logic                          vsync_out,
   output logic                          pix_valid_out
);

   localparam int unsigned COL_W = $clog2(GLYPH_W);
   localparam logic [COL_W-1:0] COL_MSB = COL_W'(GLYPH_W - 1);

   logic [GLYPH_W-1:0] w_word;
   logic [COL_W-1:0]   w_sel;
   logic               w_on;
   logic [COLOR_W-1:0] w_fg_eff;
   logic [COLOR_W-1:0] w_color;

   logic [COL_W-1:0]   r_col;
   logic               r_pv, r_hs, r_vs, r_inv;
   logic [COLOR_W-1:0] r_fg, r_bg;

   logic [COLOR_W-1:0] r_rgb;
   logic               r_hs2, r_vs2, r_pv2;

   glyph_rom #(
      .GLYPH_W    (GLYPH_W),
      .GLYPH_H    (GLYPH_H),
      .NUM_GLYPHS (NUM_GLYPHS)
   ) u_rom (
      .clk  (clk),
      .addr ({glyph_idx, glyph_row}),
      .data (w_word)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_col <= '0;
         r_pv  <= 1'b0;
         r_hs  <= 1'b0;
         r_vs  <= 1'b0;
         r_inv <= 1'b0;
         r_fg  <= '0;
         r_bg  <= '0;
      end else begin
         r_col <= glyph_col;
         r_pv  <= pix_valid;
         r_hs  <= hsync_in;
         r_vs  <= vsync_in;
         r_inv <= invert;
         r_fg  <= fg_color;
         r_bg  <= bg_color;
      end
   end

`ifdef GLYPH_BLINK_EN
   localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(BLINK_FRAMES - 1);

   logic             r_blink;
   logic             r_hidden;
   logic [CNT_W-1:0] r_frame;

   // r_vs doubles as the registered vsync copy for rising-edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_blink  <= 1'b0;
         r_hidden <= 1'b0;
         r_frame  <= '0;
      end else begin
         r_blink <= blink;
         if (vsync_in && !r_vs) begin
            if (r_frame == LAST_FRAME) begin
               r_frame  <= '0;
               r_hidden <= ~r_hidden;
            end else begin
               r_frame <= r_frame + 1'b1;
            end
         end
      end
   end
`else
   logic w_unused_blink;
   assign w_unused_blink = blink;
`endif

   always_comb begin
      w_sel    = COL_MSB - r_col;
      w_on     = w_word[w_sel] ^ r_inv;
      w_fg_eff = r_fg;
`ifdef GLYPH_BLINK_EN
      if (r_hidden && r_blink) w_fg_eff = r_bg;
`endif
      w_color  = w_on ? w_fg_eff : r_bg;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rgb <= '0;
         r_hs2 <= 1'b0;
         r_vs2 <= 1'b0;
         r_pv2 <= 1'b0;
      end else begin
         r_rgb <= r_pv ? w_color : COLOR_W'(COLOR_BLACK);
         r_hs2 <= r_hs;
         r_vs2 <= r_vs;
         r_pv2 <= r_pv;
      end
   end

   assign rgb           = r_rgb;
   assign hsync_out     = r_hs2;
   assign vsync_out     = r_vs2;
   assign pix_valid_out = r_pv2;

endmodule

// File: tb/tb_glyph_pixel_pipe.sv
// Scoreboard bench for glyph_pixel_pipe: directed and random pixels against a reference model.
module tb_glyph_pixel_pipe;
   import glyph_pkg::*;

   localparam int unsigned BF = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        pix_valid;
   logic [3:0]  glyph_idx;
   logic [4:0]  glyph_row;
   logic [3:0]  glyph_col;
   logic        hsync_in, vsync_in, blink, invert;
   logic [11:0] fg_color, bg_color;
   logic [11:0] rgb;
   logic        hsync_out, vsync_out, pix_valid_out;

   glyph_pixel_pipe #(
      .GLYPH_W      (16),
      .GLYPH_H      (32),
      .NUM_GLYPHS   (16),
      .COLOR_W      (12),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pix_valid     (pix_valid),
      .glyph_idx     (glyph_idx),
      .glyph_row     (glyph_row),
      .glyph_col     (glyph_col),
      .hsync_in      (hsync_in),
      .vsync_in      (vsync_in),
      .blink         (blink),
      .invert        (invert),
      .fg_color      (fg_color),
      .bg_color      (bg_color),
      .rgb           (rgb),
      .hsync_out     (hsync_out),
      .vsync_out     (vsync_out),
      .pix_valid_out (pix_valid_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      logic        pv;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   int          m_frames = 0;
   bit          m_hidden = 1'b0;
   bit          m_vs_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] ref_word(int g, int r);
      case (g)
         0: return (r >= 15 && r <= 17) ? 16'h0FE0 : 16'h0000;
         1: begin
            if (r == 7 || r == 10 || r == 21 || r == 24) return 16'h0300;
            if (r == 8 || r == 9 || r == 22 || r == 23) return 16'h0780;
            return 16'h0000;
         end
         2: return (((r / 2) % 2) == 0) ? 16'h0780 : 16'h0300;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [11:0] ref_rgb(int g, int r, int c, bit pv, bit bl, bit inv,
                                           logic [11:0] fg, logic [11:0] bg, bit hidden);
      logic [15:0] w;
      bit          on;
      w  = ref_word(g, r);
      on = w[15 - c] ^ inv;
      if (!pv) return 12'h000;
      if (hidden && bl) return bg;
      return on ? fg : bg;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(int g, int r, int c, bit pv, bit hs, bit vs, bit bl, bit inv,
                        logic [11:0] fg, logic [11:0] bg);
      exp_t e;
      @(negedge clk);
      glyph_idx = 4'(g);
      glyph_row = 5'(r);
      glyph_col = 4'(c);
      pix_valid = pv;
      hsync_in  = hs;
      vsync_in  = vs;
      blink     = bl;
      invert    = inv;
      fg_color  = fg;
      bg_color  = bg;
`ifdef GLYPH_BLINK_EN
      if (vs && !m_vs_prev) begin
         if (m_frames == BF - 1) begin
            m_frames = 0;
            m_hidden = !m_hidden;
         end else begin
            m_frames++;
         end
      end
`endif
      m_vs_prev = vs;
      e.rgb = ref_rgb(g, r, c, pv, bl, inv, fg, bg, m_hidden);
      e.hs  = hs;
      e.vs  = vs;
      e.pv  = pv;
      e.due = cyc + 2;
      sb.push_back(e);
   endtask

   task automatic reset_pulse();
      exp_t z;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_rgb", 32'(rgb), 32'h0);
      check("rst_hsync", 32'(hsync_out), 32'h0);
      check("rst_vsync", 32'(vsync_out), 32'h0);
      check("rst_pix_valid", 32'(pix_valid_out), 32'h0);
      sb.delete();
      m_frames  = 0;
      m_hidden  = 1'b0;
      m_vs_prev = 1'b0;
      z.rgb = 12'h000;
      z.hs  = 1'b0;
      z.vs  = 1'b0;
      z.pv  = 1'b0;
      z.due = cyc;
      sb.push_back(z);
      z.due = cyc + 1;
      sb.push_back(z);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            check("scoreboard_stale", 32'(e.due), 32'(cyc));
         end
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rgb", 32'(rgb), 32'(e.rgb));
            check("hsync_out", 32'(hsync_out), 32'(e.hs));
            check("vsync_out", 32'(vsync_out), 32'(e.vs));
            check("pix_valid_out", 32'(pix_valid_out), 32'(e.pv));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin : stimulus
      reset_n   = 1'b1;
      pix_valid = 1'b0;
      glyph_idx = '0;
      glyph_row = '0;
      glyph_col = '0;
      hsync_in  = 1'b0;
      vsync_in  = 1'b0;
      blink     = 1'b0;
      invert    = 1'b0;
      fg_color  = '0;
      bg_color  = '0;
      #1 reset_n = 1'b0;
      reset_pulse();

      drive(0, 15, 4, 1, 0, 0, 0, 0, COLOR_GREEN, COLOR_BLACK);
      drive(0, 15, 3, 1, 0, 0, 0, 0, COLOR_GREEN, COLOR_BLACK);
      drive(0, 17, 10, 1, 0, 0, 0, 0, 12'hABC, 12'h123);
      drive(0, 17, 11, 1, 0, 0, 0, 0, 12'hABC, 12'h123);
      drive(1, 8, 5, 1, 0, 0, 0, 0, 12'hF00, 12'h00F);

      for (int c = 0; c < 16; c++) drive(2, 0, c, 1, 0, 0, 0, 0, COLOR_GREEN, COLOR_BLACK);
      for (int c = 0; c < 16; c++) drive(2, 0, c, 1, 0, 0, 0, 1, COLOR_GREEN, COLOR_BLACK);

      for (int r = 0; r < 32; r += 5) drive(15, r, $urandom_range(0, 15), 1, 0, 0, 0, 0, 12'h0F0, 12'h00A);
      drive(15, 3, 7, 1, 0, 0, 0, 1, 12'h0F0, 12'h00A);

      drive(0, 15, 4, 0, 0, 0, 0, 0, COLOR_GREEN, COLOR_BLACK);
      drive(0, 15, 4, 1, 1, 0, 0, 0, COLOR_GREEN, COLOR_BLACK);
      drive(0, 15, 4, 1, 0, 0, 0, 0, COLOR_GREEN, COLOR_BLACK);
      drive(0, 15, 4, 1, 0, 0, 0, 0, COLOR_GREEN, COLOR_BLACK);

      for (int f = 0; f < 6; f++)
         for (int k = 0; k < 6; k++)
            drive(0, 15, 4, 1, 0, (k < 2), k[0], 0, COLOR_GREEN, COLOR_BLACK);

      for (int i = 0; i < 300; i++)
         drive($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 15),
               ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 12'($urandom), 12'($urandom));

      reset_pulse();

      for (int f = 0; f < 3; f++)
         for (int k = 0; k < 4; k++)
            drive(2, 1, 6, 1, 0, (k == 0), 1, 0, COLOR_GREEN, COLOR_BLACK);

      for (int i = 0; i < 100; i++)
         drive($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 15),
               ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 12'($urandom), 12'($urandom));

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      check("drain_pending", 32'(sb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
